// File: rtl/button_debounce_pkg.sv
// Shared types and sizing helpers for the push-button debouncer.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    PRS        = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_e;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs, with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: sync, stability filter, level plus rise/fall pulses.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to build the long_press hold detector.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter bit ACTIVE_HIGH       = 1'b1,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic long_press
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          pad_sync;
  logic          s;
  db_state_e     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          level_d, rise_d, fall_d;

  sync_2ff #(
    .RST_VAL (ACTIVE_HIGH ? 1'b0 : 1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button_in),
    .q     (pad_sync)
  );

  assign s = ACTIVE_HIGH ? pad_sync : ~pad_sync;

  // Counter defaults to zero so every entry into a wait state starts fresh.
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    level_d = btn_level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state)
      REL: begin
        if (s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = REL;
        end else if (cnt == CNT_LAST) begin
          state_d = PRS;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PRS: begin
        if (!s) state_d = REL_WAIT;
      end
      REL_WAIT: begin
        if (s) begin
          state_d = PRS;
        end else if (cnt == CNT_LAST) begin
          state_d = REL;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = REL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= REL;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      btn_level <= level_d;
      btn_rise  <= rise_d;
      btn_fall  <= fall_d;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  // Hold counter parks one past the threshold so each press fires at most once.
  localparam int            HW       = cnt_width(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_HIT = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT = HW'(LONG_PRESS_CYCLES);

  logic [HW-1:0] hold, hold_d;
  logic          lp_d;

  always_comb begin
    hold_d = '0;
    lp_d   = 1'b0;
    if (state == PRS) begin
      if (hold == HOLD_HIT) begin
        hold_d = HOLD_SAT;
        lp_d   = 1'b1;
      end else if (hold == HOLD_SAT) begin
        hold_d = hold;
      end else begin
        hold_d = hold + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      hold       <= hold_d;
      long_press <= lp_d;
    end
  end
`else
  // Hold threshold has no effect without the hold counter.
  logic unused_long_press_cfg;
  assign unused_long_press_cfg = (LONG_PRESS_CYCLES > 0);
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
module tb_button_debounce;

  localparam int DB = 4;
  localparam int LP = 10;
  // Edge 0 is the posedge after the drive negedge; pulse visible after edge DB+2.
  localparam int LAT = DB + 3;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_LONG = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button_in = 1'b0;
  logic btn_level, btn_rise, btn_fall, long_press;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  button_debounce #(
    .DEBOUNCE_CYCLES   (DB),
    .ACTIVE_HIGH       (1'b1),
    .LONG_PRESS_CYCLES (LP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button_in  (button_in),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .long_press (long_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, output int t);
    @(negedge clk);
    button_in = v;
    t = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, btn_level, 0);
    chk({tag, "_rise"}, btn_rise, 0);
    chk({tag, "_fall"}, btn_fall, 0);
    chk({tag, "_long"}, long_press, 0);
  endtask

  // Monitor: every pulse must match the head of the expected-event queue.
  always @(negedge clk) begin
    logic [2:0] p;
    ev_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("missed_event_cyc", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    p = {long_press, btn_fall, btn_rise};
    for (int k = 0; k < 3; k++) begin
      if (p[k]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_kind", k, -1);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", k, e.kind);
          chk("event_cyc", cyc, e.cyc);
        end
      end
    end
    if (btn_rise || btn_fall) chk("rise_fall_exclusive", int'(btn_rise & btn_fall), 0);
    if (btn_rise) chk("level_with_rise", btn_level, 1);
    if (btn_fall) chk("level_with_fall", btn_level, 0);
  end

  initial begin
    int t;
    int r;
    logic pat [6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Power-on reset
    idle(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(5);
    chk("idle_level", btn_level, 0);

    // Clean press, held long enough for the hold detector
    drive(1'b1, t);
    push(K_RISE, t + LAT);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    push(K_LONG, t + LAT + LP);
`endif
    idle(LAT - 1);
    chk("press_level_before", btn_level, 0);
    idle(1);
    chk("press_level_after", btn_level, 1);
    idle(30);
    chk("press_level_held", btn_level, 1);
`ifndef BUTTON_DEBOUNCE_LONG_PRESS_EN
    chk("long_press_off", long_press, 0);
`endif

    // Release
    drive(1'b0, t);
    push(K_FALL, t + LAT);
    idle(LAT - 1);
    chk("release_level_before", btn_level, 1);
    idle(1);
    chk("release_level_after", btn_level, 0);
    idle(5);

    // Short glitches, including one cycle short of qualifying
    for (int len = 3; len <= 4; len++) begin
      drive(1'b1, t);
      repeat (len - 1) @(negedge clk);
      drive(1'b0, t);
      idle(12);
      chk($sformatf("glitch%0d_level", len), btn_level, 0);
    end

    // Bounce then a stable press; only the final run qualifies
    foreach (pat[i]) drive(pat[i], t);
    push(K_RISE, t + LAT);
    idle(LAT + 2);
    chk("bounce_level", btn_level, 1);
    drive(1'b0, t);
    push(K_FALL, t + LAT);
    idle(LAT + 3);
    chk("bounce_release_level", btn_level, 0);

    // Reset while qualifying a held press
    drive(1'b1, t);
    idle(3);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("midreset");
    end
    rst_n = 1'b1;
    r = cyc;
    push(K_RISE, r + LAT);
    idle(LAT - 1);
    chk("post_reset_level_before", btn_level, 0);
    idle(1);
    chk("post_reset_level_after", btn_level, 1);
    drive(1'b0, t);
    push(K_FALL, t + LAT);
    idle(LAT + 5);
    chk("final_level", btn_level, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
